// File: rtl/symbol_sequencer_pkg.sv
// symbol_sequencer_pkg: shared types and sizes for the symbol sequencer.
//   state_t  : sequencer FSM states (IDLE, SEND)
//   SYM_W    : bits per symbol
//   SYMS     : symbols packed in one word
//   SEL_W    : width of the symbol select index
//   WORD_W   : width of a packed word
package symbol_sequencer_pkg;

    typedef enum logic {IDLE, SEND} state_t;

    localparam int SYM_W  = 4;
    localparam int SYMS   = 8;
    localparam int SEL_W  = 3;
    localparam int WORD_W = SYM_W * SYMS;

endpackage

// File: rtl/MUX814.sv
// MUX814: selects one 4-bit symbol out of a 32-bit word.
//   inData  : eight packed symbols, symbol k = bits 4k+3:4k
//   inSel   : index of the symbol to pass through
//   outData : selected symbol
module MUX814
    import symbol_sequencer_pkg::*;
(
    input  logic [WORD_W-1:0] inData,
    input  logic [SEL_W-1:0]  inSel,
    output logic [SYM_W-1:0]  outData
);

    assign outData = inData[inSel*SYM_W +: SYM_W];

endmodule

// File: rtl/symbol_sequencer.sv
// symbol_sequencer: accepts a packed word of 4-bit symbols and streams
// inCount+1 of them out one per handshake, LSB or MSB nibble first.
//   clk, rst      : clock, asynchronous active-high reset
//   inWord        : eight packed 4-bit symbols
//   inCount       : symbols to send minus one
//   inWordValid   : upstream offers a word
//   outWordReady  : word accepted this cycle when valid
//   outSym        : current symbol
//   outSymValid   : outSym valid
//   inSymReady    : downstream accepts outSym
//   outSel        : nibble index driving the mux
//   inFlush       : synchronous abort of the word in progress
//   outWordDone   : pulse the cycle after the last symbol is accepted
//   outBusy       : a word is held
module symbol_sequencer
    import symbol_sequencer_pkg::*;
#(
    parameter logic LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] inWord,
    input  logic [SEL_W-1:0]  inCount,
    input  logic              inWordValid,
    output logic              outWordReady,
    output logic [SYM_W-1:0]  outSym,
    output logic              outSymValid,
    input  logic              inSymReady,
    output logic [SEL_W-1:0]  outSel,
    input  logic              inFlush,
    output logic              outWordDone,
    output logic              outBusy
);

    state_t            state, state_nxt;
    logic [WORD_W-1:0] word_q;
    logic [SEL_W-1:0]  count_q, sel_q, sel_nxt, start_sel, last_sel;
    logic              done_q, sym_xfer, last_xfer, word_xfer;

    assign start_sel = LSB_FIRST ? '0 : SEL_W'(SYMS - 1);
    // Send order position inCount maps to a nibble index from the far end when MSB first.
    assign last_sel  = LSB_FIRST ? count_q : SEL_W'(SYMS - 1) - count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            word_q  <= '0;
            count_q <= '0;
            sel_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            sel_q  <= sel_nxt;
            done_q <= last_xfer && !inFlush;
            if (word_xfer) begin
                word_q  <= inWord;
                count_q <= inCount;
            end
        end
    end

    always_comb begin
        outSymValid  = (state == SEND);
        outBusy      = (state == SEND);
        sym_xfer     = outSymValid && inSymReady;
        last_xfer    = sym_xfer && (sel_q == last_sel);
        // Ready in SEND only as the last symbol leaves, so the next word follows back-to-back.
        outWordReady = !inFlush && (state == IDLE || last_xfer);
        word_xfer    = inWordValid && outWordReady;
        state_nxt    = inFlush ? IDLE : word_xfer ? SEND : last_xfer ? IDLE : state;
        sel_nxt      = inFlush ? '0 :
                       word_xfer ? start_sel :
                       (sym_xfer && !last_xfer) ? (LSB_FIRST ? sel_q + 1'b1 : sel_q - 1'b1) :
                       sel_q;
    end

    assign outSel      = sel_q;
    assign outWordDone = done_q;

    MUX814 u_mux (
        .inData (word_q),
        .inSel  (sel_q),
        .outData(outSym)
    );

endmodule
